// File: rtl/tanh_grad_if.sv
// Valid/ready stream bundle for tanh_grad: y/g pairs in, dx out.
// master = upstream producer / downstream consumer side, slave = tanh_grad.
interface tanh_grad_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] g;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dx;

    modport master (
        output in_valid, y, g, out_ready,
        input  in_ready, out_valid, dx
    );

    modport slave (
        input  in_valid, y, g, out_ready,
        output in_ready, out_valid, dx
    );
endinterface

// File: rtl/tanh_grad.sv
// tanh backward pass: dx = g * clamp(1 - y^2, 0, 1) in signed Q8.24, two-stage valid/ready pipeline.
// Define TANH_GRAD_ROUND_EN to round both >>>FL shifts to nearest instead of truncating.
module tanh_grad #(
    parameter int WIDTH = 32,
    parameter int FL    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    tanh_grad_if.slave bus
);

    localparam logic signed [WIDTH:0] ONE = $signed((WIDTH+1)'(1) << FL);
`ifdef TANH_GRAD_ROUND_EN
    localparam logic signed [2*WIDTH-1:0] RND = $signed((2*WIDTH)'(1) << (FL-1));
`else
    localparam logic signed [2*WIDTH-1:0] RND = '0;
`endif

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] ysq_q, ysq_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    logic [WIDTH-1:0] dx_q, dx_d;

    logic s1_adv, s2_adv;

    logic signed [2*WIDTH-1:0] y_ext, p1, g_ext, d_ext, p2;
    logic signed [WIDTH:0]     ysq_ext, d_val;
    logic [WIDTH-1:0]          ysq_calc, dx_calc;

    // Datapath: S1 squares the incoming y, S2 forms the clamped (1 - y^2) and scales g
    always_comb begin
        y_ext    = {{WIDTH{bus.y[WIDTH-1]}}, bus.y};
        p1       = y_ext * y_ext + RND;
        ysq_calc = WIDTH'(p1 >>> FL);

        // A wrapped (negative) square can only come from a huge |y|; treat it as y^2 = 0
        ysq_ext = {ysq_q[WIDTH-1], ysq_q};
        if (ysq_ext > ONE)
            d_val = '0;
        else if (ysq_ext[WIDTH])
            d_val = ONE;
        else
            d_val = ONE - ysq_ext;

        g_ext   = {{WIDTH{g1_q[WIDTH-1]}}, g1_q};
        d_ext   = {{(WIDTH-1){d_val[WIDTH]}}, d_val};
        p2      = g_ext * d_ext + RND;
        dx_calc = WIDTH'(p2 >>> FL);
    end

    assign s2_adv        = !s2_valid_q || bus.out_ready;
    assign s1_adv        = !s1_valid_q || s2_adv;
    assign bus.in_ready  = en && rst && s1_adv;
    assign bus.out_valid = en && s2_valid_q;
    assign bus.dx        = dx_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        ysq_d      = ysq_q;
        g1_d       = g1_q;
        dx_d       = dx_q;
        if (en) begin
            if (s1_adv) begin
                s1_valid_d = bus.in_valid;
                if (bus.in_valid) begin
                    ysq_d = ysq_calc;
                    g1_d  = bus.g;
                end
            end
            // dx only changes when a real entry moves in, so it holds after the last result drains
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q)
                    dx_d = dx_calc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            ysq_q      <= '0;
            g1_q       <= '0;
            dx_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            ysq_q      <= ysq_d;
            g1_q       <= g1_d;
            dx_q       <= dx_d;
        end
    end

endmodule

// File: tb/tb_tanh_grad.sv
// Directed bench for tanh_grad: vector table plus backpressure, reset and enable-freeze sequences.
module tb_tanh_grad;

    logic clk;
    logic rst;
    logic en;
    int   checks = 0;
    int   errors = 0;

    tanh_grad_if #(.WIDTH(32)) bif ();

    tanh_grad #(.WIDTH(32), .FL(24)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] y;
        logic [31:0] g;
        logic [31:0] dx;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] yv, input logic [31:0] gv);
        bif.in_valid = v;
        bif.y        = yv;
        bif.g        = gv;
    endtask

    initial begin
        vt[0] = '{32'h0000_0000, 32'h0100_0000, 32'h0100_0000};
        vt[1] = '{32'h0080_0000, 32'h0100_0000, 32'h00C0_0000};
        vt[2] = '{32'hFF80_0000, 32'hFE00_0000, 32'hFE80_0000};
        vt[3] = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000};
        vt[4] = '{32'h0180_0000, 32'h0100_0000, 32'h0000_0000};
`ifdef TANH_GRAD_ROUND_EN
        vt[5] = '{32'h0080_0000, 32'h0000_0001, 32'h0000_0001};
`else
        vt[5] = '{32'h0080_0000, 32'h0000_0001, 32'h0000_0000};
`endif
        vt[6] = '{32'h0040_0000, 32'h0040_0000, 32'h003C_0000};
        vt[7] = '{32'h00C0_0000, 32'h0200_0000, 32'h00E0_0000};
        vt[8] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        vt[9] = '{32'h0080_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst           = 1'b0;
        en            = 1'b1;
        bif.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        #1;
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_dx", bif.dx, 32'h0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_in_ready", 32'(bif.in_ready), 32'd1);

        // Isolated transactions: nothing at one cycle, result at two
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].y, vt[i].g);
            @(negedge clk);
            drive(1'b0, '0, '0);
            chk($sformatf("vec%0d_lat1_valid", i), 32'(bif.out_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bif.out_valid), 32'd1);
            chk($sformatf("vec%0d_dx", i), bif.dx, vt[i].dx);
        end

        // Back-to-back stream: one accept and one result per cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk($sformatf("thru%0d_valid", k - 2), 32'(bif.out_valid), 32'd1);
                chk($sformatf("thru%0d_dx", k - 2), bif.dx, vt[k-2].dx);
            end
            if (k < 4) begin
                drive(1'b1, vt[k].y, vt[k].g);
                #1 chk($sformatf("thru%0d_in_ready", k), 32'(bif.in_ready), 32'd1);
            end else begin
                drive(1'b0, '0, '0);
            end
        end
        @(negedge clk);
        chk("thru_drain_valid", 32'(bif.out_valid), 32'd0);

        // Backpressure: two accepted, third held off, dx stable, then drain in order
        @(negedge clk);
        bif.out_ready = 1'b0;
        drive(1'b1, vt[0].y, vt[0].g);
        @(negedge clk);
        chk("bp_b_in_ready", 32'(bif.in_ready), 32'd1);
        drive(1'b1, vt[1].y, vt[1].g);
        @(negedge clk);
        drive(1'b1, vt[6].y, vt[6].g);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("bp_stall%0d_in_ready", c), 32'(bif.in_ready), 32'd0);
            chk($sformatf("bp_stall%0d_valid", c), 32'(bif.out_valid), 32'd1);
            chk($sformatf("bp_stall%0d_dx", c), bif.dx, vt[0].dx);
        end
        @(negedge clk);
        bif.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 32'(bif.in_ready), 32'd1);
        chk("bp_out0_dx", bif.dx, vt[0].dx);
        @(negedge clk);
        drive(1'b0, '0, '0);
        chk("bp_out1_valid", 32'(bif.out_valid), 32'd1);
        chk("bp_out1_dx", bif.dx, vt[1].dx);
        @(negedge clk);
        chk("bp_out2_valid", 32'(bif.out_valid), 32'd1);
        chk("bp_out2_dx", bif.dx, vt[6].dx);
        @(negedge clk);
        chk("bp_done_valid", 32'(bif.out_valid), 32'd0);

        // Reset with two entries in flight
        bif.out_ready = 1'b0;
        drive(1'b1, vt[1].y, vt[1].g);
        @(negedge clk);
        drive(1'b1, vt[2].y, vt[2].g);
        @(negedge clk);
        drive(1'b0, '0, '0);
        chk("mid_pre_valid", 32'(bif.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_dx", bif.dx, 32'h0);
        chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd0);
        drive(1'b1, vt[7].y, vt[7].g);
        @(negedge clk);
        chk("mid_rst_hold_in_ready", 32'(bif.in_ready), 32'd0);
        @(negedge clk);
        drive(1'b0, '0, '0);
        rst           = 1'b1;
        bif.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid_nostale%0d_valid", c), 32'(bif.out_valid), 32'd0);
        end
        drive(1'b1, vt[7].y, vt[7].g);
        @(negedge clk);
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("mid_new_valid", 32'(bif.out_valid), 32'd1);
        chk("mid_new_dx", bif.dx, vt[7].dx);
        @(negedge clk);

        // en=0 for five cycles with two entries in flight
        bif.out_ready = 1'b0;
        drive(1'b1, vt[1].y, vt[1].g);
        @(negedge clk);
        drive(1'b1, vt[2].y, vt[2].g);
        @(negedge clk);
        en            = 1'b0;
        bif.out_ready = 1'b1;
        drive(1'b1, vt[9].y, vt[9].g);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("en_off%0d_valid", c), 32'(bif.out_valid), 32'd0);
            chk($sformatf("en_off%0d_in_ready", c), 32'(bif.in_ready), 32'd0);
            chk($sformatf("en_off%0d_dx", c), bif.dx, vt[1].dx);
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("en_on_valid", 32'(bif.out_valid), 32'd1);
        chk("en_on_in_ready", 32'(bif.in_ready), 32'd1);
        chk("en_on_dx0", bif.dx, vt[1].dx);
        @(negedge clk);
        drive(1'b0, '0, '0);
        chk("en_on_dx1", bif.dx, vt[2].dx);
        @(negedge clk);
        chk("en_on_valid2", 32'(bif.out_valid), 32'd1);
        chk("en_on_dx2", bif.dx, vt[9].dx);
        @(negedge clk);
        chk("en_on_drain_valid", 32'(bif.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
